// File: rtl/gj_aurora_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one Aurora TX AXI-Stream port among N_REQ sources.
// Optional frame-length watchdog enabled by defining GJ_ARB_WATCHDOG_EN.
module gj_aurora_tx_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic                       user_clk,
  input  logic                       peripheral_aresetn,
  input  logic [N_REQ*DATA_W-1:0]    s_axis_tdata,
  input  logic [N_REQ-1:0]           s_axis_tvalid,
  input  logic [N_REQ-1:0]           s_axis_tlast,
  output logic [N_REQ-1:0]           s_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  input  logic                       channel_up,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic [3:0]                 error_count
);

  localparam int unsigned GW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [3:0]        err_q, err_d;
  logic [3:0]        err_inc;
  logic [GW-1:0]     next_req;
  logic              found;
  logic [DATA_W-1:0] g_data;
  logic              g_valid;
  logic              g_last;
  logic              wd_hit;

  always_comb begin
    g_data  = s_axis_tdata[grant_q*DATA_W +: DATA_W];
    g_valid = s_axis_tvalid[grant_q];
    g_last  = s_axis_tlast[grant_q];
    err_inc = (err_q == 4'hF) ? err_q : err_q + 4'd1;
  end

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    next_req = grant_q;
    found    = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned idx;
      idx = (32'(grant_q) + k) % N_REQ;
      if (!found && s_axis_tvalid[idx]) begin
        found    = 1'b1;
        next_req = GW'(idx);
      end
    end
  end

`ifdef GJ_ARB_WATCHDOG_EN
  localparam int unsigned BW = $clog2(MAX_BEATS + 1);

  logic [BW-1:0] beats_q, beats_d;

  always_comb begin
    wd_hit  = (beats_q == BW'(MAX_BEATS - 1));
    beats_d = beats_q;
    if (state_q == IDLE) begin
      beats_d = '0;
    end else if (state_q == GRANT && channel_up && g_valid && m_axis_tready) begin
      beats_d = beats_q + 1'b1;
    end
  end

  always_ff @(posedge user_clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      beats_q <= '0;
    end else begin
      beats_q <= beats_d;
    end
  end
`else
  always_comb wd_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    err_d         = err_q;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      IDLE: begin
        if (channel_up && found) begin
          grant_d = next_req;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A link drop blanks the m-side in the same cycle and holds the source.
        if (!channel_up) begin
          state_d = FLUSH;
          err_d   = err_inc;
        end else begin
          m_axis_tdata           = g_data;
          m_axis_tvalid          = g_valid;
          m_axis_tlast           = g_last | wd_hit;
          s_axis_tready[grant_q] = m_axis_tready;
          if (g_valid && m_axis_tready) begin
            if (g_last) begin
              state_d = IDLE;
            end else if (wd_hit) begin
              state_d = FLUSH;
              err_d   = err_inc;
            end
          end
        end
      end
      FLUSH: begin
        s_axis_tready[grant_q] = 1'b1;
        if (g_valid && g_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      state_q <= IDLE;
      grant_q <= GW'(N_REQ - 1);
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    grant_id    = grant_q;
    busy        = (state_q != IDLE);
    error_count = err_q;
  end

endmodule

// File: tb/tb_gj_aurora_tx_arbiter.sv
// Randomized and directed bench for gj_aurora_tx_arbiter with a frame-level behavioural model.
// Honours GJ_ARB_WATCHDOG_EN with MAX_BEATS=16.
module tb_gj_aurora_tx_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int MAX = 16;

  typedef struct { logic last; logic [W-1:0] data; } beat_t;
  typedef struct { int src; logic last; logic [W-1:0] data; } rx_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N*W-1:0]   s_axis_tdata = '0;
  logic [N-1:0]     s_axis_tvalid = '0;
  logic [N-1:0]     s_axis_tlast = '0;
  logic [N-1:0]     s_axis_tready;
  logic [W-1:0]     m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready = 1'b1;
  logic             channel_up = 1'b1;
  logic [1:0]       grant_id;
  logic             busy;
  logic [3:0]       error_count;

  gj_aurora_tx_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BEATS(MAX)) dut (
    .user_clk(clk), .peripheral_aresetn(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .channel_up(channel_up), .grant_id(grant_id), .busy(busy),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    errors  = 0;
  beat_t q[N][$];
  rx_t   rx[$];
  logic [N-1:0] hs = '0;
  int    gap_mode = 0;
  int    mr_mode  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int r, input logic [W-1:0] base, input int len);
    for (int k = 0; k < len; k++) q[r].push_back('{last: (k == len - 1), data: base + W'(k)});
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Sources: hold a presented beat until accepted, optionally insert gaps between beats.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        q[i].delete();
        s_axis_tvalid[i] = 1'b0;
      end else begin
        if (hs[i] && q[i].size() > 0) begin
          void'(q[i].pop_front());
          s_axis_tvalid[i] = 1'b0;
        end
        if (q[i].size() > 0) begin
          if (!s_axis_tvalid[i]) s_axis_tvalid[i] = (gap_mode == 0) || ($urandom_range(3) != 0);
          s_axis_tdata[i*W +: W] = q[i][0].data;
          s_axis_tlast[i]        = q[i][0].last;
        end else begin
          s_axis_tvalid[i]       = 1'b0;
          s_axis_tdata[i*W +: W] = $urandom;
          s_axis_tlast[i]        = 1'($urandom_range(1));
        end
      end
    end
    case (mr_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = ($urandom_range(3) != 0);
    endcase
  end

  // Reference model: who owns the port, whether we are discarding, beats sent, abort count.
  int  m_last = N - 1;
  bit  m_busy = 0;
  bit  m_flush = 0;
  int  m_beats = 0;
  int  m_err = 0;

  always @(negedge clk) begin
    logic [N-1:0] e_tready;
    logic [W-1:0] e_data;
    logic e_valid, e_lastb, wd, cu, mr, gv, gl;
    bit found;
    int idx;
    if (!rst_n) begin
      m_last = N - 1; m_busy = 0; m_flush = 0; m_beats = 0; m_err = 0; hs = '0;
    end else begin
      cu = channel_up; mr = m_axis_tready;
      gv = s_axis_tvalid[m_last]; gl = s_axis_tlast[m_last];
`ifdef GJ_ARB_WATCHDOG_EN
      wd = (m_beats == MAX - 1);
`else
      wd = 1'b0;
`endif
      e_tready = '0; e_data = '0; e_valid = 1'b0; e_lastb = 1'b0;
      if (m_busy && !m_flush && cu) begin
        e_data = s_axis_tdata[m_last*W +: W];
        e_valid = gv; e_lastb = gl | wd;
        e_tready[m_last] = mr;
      end else if (m_busy && m_flush) begin
        e_tready[m_last] = 1'b1;
      end
      chk("tready", s_axis_tready, e_tready);
      chk("tvalid", m_axis_tvalid, e_valid);
      chk("tlast", m_axis_tlast, e_lastb);
      chk("tdata", m_axis_tdata, e_data);
      chk("grant_id", grant_id, m_last);
      chk("busy", busy, m_busy);
      chk("error_count", error_count, m_err);
      if (m_axis_tvalid && m_axis_tready) rx.push_back('{src: int'(grant_id), last: m_axis_tlast, data: m_axis_tdata});
      hs = s_axis_tvalid & s_axis_tready;
      if (!m_busy) begin
        if (cu && |s_axis_tvalid) begin
          found = 0;
          for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (!found && s_axis_tvalid[idx]) begin found = 1; m_last = idx; end
          end
          m_busy = 1; m_flush = 0; m_beats = 0;
        end
      end else if (!m_flush) begin
        if (!cu) begin
          m_flush = 1; m_err = (m_err < 15) ? m_err + 1 : 15;
        end else if (gv && mr) begin
          m_beats++;
          if (gl) m_busy = 0;
          else if (wd) begin m_flush = 1; m_err = (m_err < 15) ? m_err + 1 : 15; end
        end
      end else if (gv && gl) begin
        m_busy = 0; m_flush = 0;
      end
    end
  end

  task automatic drain(input int budget, input string nm);
    int c = 0;
    while ((any_pending() || busy) && c < budget) begin @(posedge clk); c++; end
    chk(nm, (c < budget), 1'b1);
    @(posedge clk);
  endtask

  task automatic wait_rx(input int n, input string nm);
    int c = 0;
    while (rx.size() < n && c < 200) begin @(posedge clk); c++; end
    chk(nm, (rx.size() >= n), 1'b1);
  endtask

  initial begin
    int exp_src[6] = '{0, 1, 3, 0, 1, 3};
    int n0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 3);
    chk("rst_err", error_count, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_mlast", m_axis_tlast, 0);
    chk("rst_mdata", m_axis_tdata, 0);
    #2 rst_n = 1'b1;

    // 4-beat frame from requester 2
    rx.delete();
    push_frame(2, 32'hA0, 4);
    drain(100, "t1_timeout");
    chk("t1_count", rx.size(), 4);
    for (int k = 0; k < rx.size(); k++) begin
      chk("t1_data", rx[k].data, 32'hA0 + k);
      chk("t1_last", rx[k].last, (k == 3));
      chk("t1_src", rx[k].src, 2);
    end
    chk("t1_err", error_count, 0);

    // single-beat frame
    rx.delete();
    push_frame(3, 32'h55, 1);
    drain(100, "single_timeout");
    chk("single_count", rx.size(), 1);
    if (rx.size() > 0) chk("single_last", rx[0].last, 1);
    chk("single_busy", busy, 0);

    // three busy requesters, round-robin order
    rx.delete();
    for (int j = 0; j < 2; j++) begin
      push_frame(0, 32'h300 + j * 2, 2);
      push_frame(1, 32'h310 + j * 2, 2);
      push_frame(3, 32'h330 + j * 2, 2);
    end
    drain(200, "rr_timeout");
    chk("rr_count", rx.size(), 12);
    for (int f = 0; f < 6 && 2 * f + 1 < rx.size(); f++) begin
      chk("rr_src", rx[2*f].src, exp_src[f]);
      chk("rr_data", rx[2*f+1].data, 32'h300 + exp_src[f] * 16 + (f / 3) * 2 + 1);
    end

    // tready toggling
    rx.delete();
    mr_mode = 1;
    push_frame(0, 32'h80, 8);
    drain(200, "toggle_timeout");
    mr_mode = 0;
    chk("toggle_count", rx.size(), 8);
    for (int k = 0; k < rx.size(); k++) chk("toggle_data", rx[k].data, 32'h80 + k);

    // link drop after beat 3 of 10
    rx.delete();
    push_frame(0, 32'h100, 10);
    wait_rx(3, "drop_wait");
    #1 channel_up = 1'b0;
    drain(200, "drop_flush_timeout");
    chk("drop_count", rx.size(), 3);
    chk("drop_err", error_count, 1);
    push_frame(1, 32'h140, 2);
    repeat (10) @(posedge clk);
    chk("drop_nogrant_busy", busy, 0);
    chk("drop_nogrant_rx", rx.size(), 3);
    #1 channel_up = 1'b1;
    drain(100, "drop_resume_timeout");
    chk("drop_resume_count", rx.size(), 5);

    // 20-beat frame vs watchdog
    rx.delete();
    push_frame(2, 32'h200, 20);
    drain(300, "wd_timeout");
`ifdef GJ_ARB_WATCHDOG_EN
    chk("wd_count", rx.size(), 16);
    if (rx.size() == 16) chk("wd_forced_last", rx[15].last, 1);
    chk("wd_err", error_count, 2);
`else
    chk("wd_count", rx.size(), 20);
    if (rx.size() == 20) chk("wd_last", rx[19].last, 1);
    chk("wd_err", error_count, 1);
`endif

    // randomized traffic with occasional link drops and backpressure
    gap_mode = 1; mr_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1 channel_up = ($urandom_range(49) != 0);
      if ($urandom_range(7) == 0) begin
        int r;
        r = $urandom_range(N - 1);
        if (q[r].size() < 30) push_frame(r, $urandom, $urandom_range(20, 1));
      end
    end
    #1 channel_up = 1'b1;
    mr_mode = 0;
    drain(3000, "rand_drain_timeout");
    gap_mode = 0;

    // 17 aborted frames saturate the counter
    for (int a = 0; a < 17; a++) begin
      rx.delete();
      push_frame(1, 32'h400 + a * 8, 4);
      wait_rx(1, "abort_wait");
      #1 channel_up = 1'b0;
      @(posedge clk);
      #1 channel_up = 1'b1;
      drain(100, "abort_timeout");
    end
    chk("sat_err", error_count, 15);

    // asynchronous reset mid-frame
    rx.delete();
    push_frame(0, 32'h500, 6);
    wait_rx(2, "mid_rst_wait");
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mvalid", m_axis_tvalid, 0);
    chk("mid_rst_tready", s_axis_tready, 0);
    chk("mid_rst_err", error_count, 0);
    chk("mid_rst_grant", grant_id, 3);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2;
    rx.delete();
    n0 = 0;
    push_frame(1, 32'h610, 2);
    push_frame(0, 32'h600, 2);
    drain(100, "post_rst_timeout");
    chk("post_rst_count", rx.size(), 4);
    if (rx.size() > n0) chk("post_rst_first_src", rx[n0].src, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/gj_aurora_tx_arbiter.md
# gj_aurora_tx_arbiter

Frame-level round-robin arbiter that shares the single Aurora 8b/10b TX AXI-Stream port of the gap-junction emulator among `N_REQ` packet sources. It sits between the per-source packet builders and the Aurora core user interface in the GapJuntionEmu block design. It gates traffic on `channel_up`, flushes frames cut by a link drop, and reports abort events on a saturating 4-bit error counter.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8
- `DATA_W`, 32 — AXI-Stream data width, matches the Aurora user interface
- `MAX_BEATS`, 256 — frame length limit used by the watchdog, ≥2
- `user_clk` input 1 — Aurora user clock; all logic on its rising edge
- `peripheral_aresetn` input 1 — asynchronous, active-low reset
- `s_axis_tdata` input N_REQ*DATA_W — requester data; requester i occupies bits [i*DATA_W +: DATA_W]
- `s_axis_tvalid` input N_REQ — per-requester valid
- `s_axis_tlast` input N_REQ — per-requester end of frame
- `s_axis_tready` output N_REQ — per-requester ready
- `m_axis_tdata` output DATA_W — to the Aurora TX
- `m_axis_tvalid` output 1 — to the Aurora TX
- `m_axis_tlast` output 1 — to the Aurora TX
- `m_axis_tready` input 1 — from the Aurora TX
- `channel_up` input 1 — Aurora link status, synchronous to `user_clk`
- `grant_id` output $clog2(N_REQ) — current or last granted requester
- `busy` output 1 — high in GRANT or FLUSH
- `error_count` output 4 — saturating count of aborted frames

## Operation
- FSM states: IDLE, GRANT, FLUSH.
- IDLE
  - All `s_axis_tready`=0 and `m_axis_tvalid`=0.
  - If `channel_up`=1 and any `s_axis_tvalid`=1: select the first valid requester searching from `grant_id`+1 (mod N_REQ, wrapping). Register it into `grant_id` and go to GRANT.
  - After reset the search starts at requester 0.
- GRANT
  - Combinational pass-through of granted requester g:
    - `m_axis_tdata`/`m_axis_tvalid`/`m_axis_tlast` = requester g's `s_axis_tdata`/`s_axis_tvalid`/`s_axis_tlast`.
    - `s_axis_tready[g]` = `m_axis_tready`; all other readies are 0.
  - Beat counter increments on each m-side handshake.
  - A handshake with tlast=1 returns the FSM to IDLE.
  - `channel_up` low in any GRANT cycle: go to FLUSH and increment `error_count`. That cycle's m-side outputs are already forced to 0.
- FLUSH
  - `m_axis_tvalid`=0; `s_axis_tready[g]`=1, so requester g's beats are discarded.
  - Leave to IDLE on a requester g handshake with tlast=1.
- `error_count` saturates at 15 and is cleared only by reset.
- Requests never preempt a frame in progress.
- `grant_id` holds its value in IDLE.

## Timing
- Reset values:
  - FSM = IDLE, `grant_id`=N_REQ-1, so the first search starts at 0.
  - `busy`=0, `error_count`=0, all `s_axis_tready`=0.
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
- Latency:
  - A request seen in IDLE at edge k is in GRANT from edge k+1; the first beat can hand off in cycle k+1.
  - Data path has zero added latency; no data register.
- One IDLE bubble cycle between consecutive frames.
- A requester dropping `s_axis_tvalid` mid-frame keeps its grant; `m_axis_tvalid` follows it low.
- A frame whose first beat has tlast=1 (single beat): GRANT for one handshake, then IDLE.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous); the partial frame is lost; no count.
- `channel_up` low in IDLE: no grant is issued; pending requests wait.

## Configuration
- Macro: `GJ_ARB_WATCHDOG_EN`.
- Defined:
  - In GRANT, the handshake of beat number MAX_BEATS (counting from 1) is driven with `m_axis_tlast`=1 regardless of the source.
  - If the source tlast was 0: go to FLUSH and increment `error_count`.
  - If the source tlast was 1: go to IDLE normally.
- Undefined: no length limit; the beat counter is absent; frames of any length pass.

## Test plan
- Reset, channel_up=1, requester 2 sends a 4-beat frame 0xA0..0xA3 -> `grant_id`=2, Aurora receives 4 beats with tlast on 0xA3, `error_count`=0.
- Requesters 0,1,3 continuously valid with 2-beat frames -> frame order 0,1,3,0,1,3, one idle cycle between frames.
- `m_axis_tready` toggling 1/0 every cycle during an 8-beat frame -> all 8 beats delivered in order, none duplicated.
- `channel_up` drops after beat 3 of a 10-beat frame -> Aurora sees 3 beats; remaining 7 accepted and discarded; `error_count`=1; no grant until `channel_up` returns.
- With `GJ_ARB_WATCHDOG_EN`, MAX_BEATS=16, 20-beat frame -> forced tlast on beat 16, beats 17..20 flushed, `error_count`=1. Without the macro, all 20 beats pass.
- 17 aborted frames -> `error_count` stays 15.
